// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Brief    : Opcode/handshake inputs and datapath strobe bundle between the
//            multicycle control unit (master) and the datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
  logic [6:0] opcode_i;
  logic       branch_taken_i;
  logic       mem_ready_i;
  logic [2:0] ALU_Op_o;
  logic       ALU_Src_A_o;
  logic [1:0] ALU_Src_B_o;
  logic       PC_Write_o;
  logic [1:0] PC_Src_o;
  logic       IR_Write_o;
  logic       I_or_D_o;
  logic       Mem_Read_o;
  logic       Mem_Write_o;
  logic       Reg_Write_o;
  logic [1:0] Mem_to_Reg_o;
  logic       Instr_Done_o;
  logic       Illegal_o;

  // Control unit side: consumes opcode/handshakes, drives strobes
  modport master (
    input  opcode_i, branch_taken_i, mem_ready_i,
    output ALU_Op_o, ALU_Src_A_o, ALU_Src_B_o, PC_Write_o, PC_Src_o,
           IR_Write_o, I_or_D_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
           Mem_to_Reg_o, Instr_Done_o, Illegal_o
  );

  // Datapath side
  modport slave (
    output opcode_i, branch_taken_i, mem_ready_i,
    input  ALU_Op_o, ALU_Src_A_o, ALU_Src_B_o, PC_Write_o, PC_Src_o,
           IR_Write_o, I_or_D_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
           Mem_to_Reg_o, Instr_Done_o, Illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : RV32I-subset multicycle sequencer: FETCH/DECODE/EXECUTE/MEM/WB
//            with memory ready handshake and illegal-opcode TRAP.
// Options  : PERF_COUNTERS_EN adds cycle_count_o / instret_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  multicycle_control_unit_if.master bus
`ifdef PERF_COUNTERS_EN
  ,
  output logic [COUNT_WIDTH-1:0] cycle_count_o,
  output logic [COUNT_WIDTH-1:0] instret_count_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R = 4'd0, C_I = 4'd1, C_LW = 4'd2, C_SW = 4'd3, C_LUI = 4'd4,
    C_BR = 4'd5, C_JAL = 4'd6, C_JALR = 4'd7, C_ILL = 4'd8
  } cls_t;

  state_t state, next_state;
  cls_t   cls, next_cls;

  // Moore outputs, registered from the state being entered
  logic [2:0] alu_op;
  logic       src_a;
  logic [1:0] src_b;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] mem_to_reg;
  logic       done;
  logic       illegal;

  // Opcode class decode, only consumed while in DECODE
  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: classify = C_R;
      7'b0010011: classify = C_I;
      7'b0000011: classify = C_LW;
      7'b0100011: classify = C_SW;
      7'b0110111: classify = C_LUI;
      7'b1100011: classify = C_BR;
      7'b1101111: classify = C_JAL;
      7'b1100111: classify = C_JALR;
      default:    classify = C_ILL;
    endcase
  endfunction

  // Next-state and next-class selection
  always_comb begin
    next_state = state;
    next_cls   = cls;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  if (bus.mem_ready_i) next_state = S_DECODE;
      S_DECODE: begin
        next_cls   = classify(bus.opcode_i);
        next_state = (next_cls == C_ILL) ? S_TRAP : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (cls == C_LW || cls == C_SW) next_state = S_MEM;
        else if (cls == C_BR)           next_state = S_FETCH;
        else                            next_state = S_WB;
      end
      S_MEM:    if (bus.mem_ready_i) next_state = (cls == C_LW) ? S_WB : S_FETCH;
      S_WB:     next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_IDLE;
    endcase
  end

  // State, class and Moore strobes; reset drops every strobe at the edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;     cls <= C_R;
      alu_op <= 3'b000;    src_a <= 1'b0;     src_b <= 2'b00;
      pc_write <= 1'b0;    pc_src <= 2'b00;   i_or_d <= 1'b0;
      mem_read <= 1'b0;    mem_write <= 1'b0; reg_write <= 1'b0;
      mem_to_reg <= 2'b00; done <= 1'b0;      illegal <= 1'b0;
    end else begin
      state <= next_state; cls <= next_cls;
      alu_op <= 3'b000;    src_a <= 1'b0;     src_b <= 2'b00;
      pc_write <= 1'b0;    pc_src <= 2'b00;   i_or_d <= 1'b0;
      mem_read <= 1'b0;    mem_write <= 1'b0; reg_write <= 1'b0;
      mem_to_reg <= 2'b00; done <= 1'b0;      illegal <= 1'b0;
      case (next_state)
        S_FETCH: mem_read <= 1'b1;
        S_EXECUTE: begin
          case (next_cls)
            C_R:     alu_op <= 3'b000;
            C_LUI:   alu_op <= 3'b010;
            C_BR:    alu_op <= 3'b100;
            C_JAL:   alu_op <= 3'b101;
            default: alu_op <= 3'b001;
          endcase
          src_a <= !(next_cls == C_BR || next_cls == C_JAL);
          src_b <= (next_cls == C_R || next_cls == C_BR) ? 2'b00 : 2'b01;
          if (next_cls == C_BR) begin
            pc_src <= 2'b01;
            done   <= 1'b1;
          end
        end
        S_MEM: begin
          i_or_d    <= 1'b1;
          mem_read  <= (next_cls == C_LW);
          mem_write <= (next_cls == C_SW);
        end
        S_WB: begin
          reg_write <= 1'b1;
          done      <= 1'b1;
          if (next_cls == C_LW) begin
            mem_to_reg <= 2'b01;
          end else if (next_cls == C_JAL || next_cls == C_JALR) begin
            mem_to_reg <= 2'b10;
            pc_write   <= 1'b1;
            pc_src     <= 2'b10;
          end
        end
        S_TRAP:  illegal <= 1'b1;
        default: ;
      endcase
    end
  end

  // Mealy terms: fetch completion, taken branch, store completion
  logic fetch_done, br_taken, sw_done;
  assign fetch_done = (state == S_FETCH) && bus.mem_ready_i;
  assign br_taken   = (state == S_EXECUTE) && (cls == C_BR) && bus.branch_taken_i;
  assign sw_done    = (state == S_MEM) && (cls == C_SW) && bus.mem_ready_i;

  assign bus.ALU_Op_o     = alu_op;
  assign bus.ALU_Src_A_o  = src_a;
  assign bus.ALU_Src_B_o  = src_b;
  assign bus.PC_Write_o   = pc_write | fetch_done | br_taken;
  assign bus.PC_Src_o     = pc_src;
  assign bus.IR_Write_o   = fetch_done;
  assign bus.I_or_D_o     = i_or_d;
  assign bus.Mem_Read_o   = mem_read;
  assign bus.Mem_Write_o  = mem_write;
  assign bus.Reg_Write_o  = reg_write;
  assign bus.Mem_to_Reg_o = mem_to_reg;
  assign bus.Instr_Done_o = done | sw_done;
  assign bus.Illegal_o    = illegal;

`ifdef PERF_COUNTERS_EN
  // Free-running cycle and retired-instruction counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_o   <= '0;
      instret_count_o <= '0;
    end else begin
      cycle_count_o <= cycle_count_o + 1'b1;
      if (bus.Instr_Done_o) instret_count_o <= instret_count_o + 1'b1;
    end
  end
`else
  logic unused_count_width;
  assign unused_count_width = ^COUNT_WIDTH;
`endif

endmodule
`default_nettype wire
